// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants.
// Register-file widths, the zero register and sequencer states.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sweep for the register file.
// Walks every address once, writing zero, then raises ready.
module rf_clear_seq
  import mips_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  rf_state_t     state;
  rf_state_t     state_n;
  logic [AW-1:0] cnt;
  logic [AW-1:0] cnt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt parks at its terminal value so it never wraps
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr_we  = 1'b0;
    ready   = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we = ~reset;
        if (cnt == '1) begin
          state_n = RUN;
        end else begin
          cnt_n = cnt + AW'(1);
        end
      end
      RUN: begin
        ready = 1'b1;
      end
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_2r1w.sv
// Two-read, one-write MIPS register file with registered reads,
// write-first bypass, hardwired r0 and a post-reset clear sweep.
module regfile_2r1w
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int AW    = REG_AW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [AW-1:0]    rw,
  input  logic [WIDTH-1:0] busw,
  input  logic             regwr,
  output logic [WIDTH-1:0] busa,
  output logic [WIDTH-1:0] busb,
  output logic             ready
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             rdy;

  logic             usr_we;
  logic             we;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             byp_a;
  logic             byp_b;

  logic [WIDTH-1:0] mem [DEPTH];

  rf_clear_seq #(
    .AW(AW)
  ) u_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (rdy)
  );

  assign ready = rdy;

  // user writes only land once the sweep is done
  assign usr_we = rdy & ~reset & regwr & (rw != ZERO);

  always_comb begin
    we = clr_we | usr_we;
    wa = clr_we ? clr_addr : rw;
    wd = clr_we ? '0 : busw;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign byp_a = usr_we & (rw == ra);
  assign byp_b = usr_we & (rw == rb);

  always_ff @(posedge clk) begin
    if (reset || !rdy) begin
      busa <= '0;
      busb <= '0;
    end else begin
      if (ra == ZERO) begin
        busa <= '0;
      end else if (byp_a) begin
        busa <= busw;
      end else begin
        busa <= mem[ra];
      end
      if (rb == ZERO) begin
        busb <= '0;
      end else if (byp_b) begin
        busb <= busw;
      end else begin
        busb <= mem[rb];
      end
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w.
// A reference model pushes expected buses; outputs are popped after each edge.
module tb_regfile_2r1w;

  logic        clk;
  logic        reset;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic [4:0]  rw;
  logic [31:0] busw;
  logic        regwr;
  logic [31:0] busa;
  logic [31:0] busb;
  logic        ready;

  regfile_2r1w dut (
    .clk   (clk),
    .reset (reset),
    .ra    (ra),
    .rb    (rb),
    .rw    (rw),
    .busw  (busw),
    .regwr (regwr),
    .busa  (busa),
    .busb  (busb),
    .ready (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] m_mem[32];
  logic        m_run;
  logic [4:0]  m_cnt;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic we,
                       input logic [4:0] w, input logic [31:0] d,
                       input logic [4:0] a, input logic [4:0] b,
                       input string tag);
    exp_t e;
    e.tag = tag;
    reset = rst;
    regwr = we;
    rw    = w;
    busw  = d;
    ra    = a;
    rb    = b;
    if (rst) begin
      m_run = 1'b0;
      m_cnt = 5'd0;
      e.a = '0;
      e.b = '0;
    end else if (!m_run) begin
      m_mem[m_cnt] = '0;
      if (m_cnt == 5'd31) m_run = 1'b1;
      else m_cnt = m_cnt + 5'd1;
      e.a = '0;
      e.b = '0;
    end else begin
      e.a = (a == 0) ? '0 : (we && w != 0 && w == a) ? d : m_mem[a];
      e.b = (b == 0) ? '0 : (we && w != 0 && w == b) ? d : m_mem[b];
      if (we && w != 0) m_mem[w] = d;
    end
    e.r = m_run;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_busa"}, busa, e.a);
      chk({e.tag, "_busb"}, busb, e.b);
      chk({e.tag, "_ready"}, {31'd0, ready}, {31'd0, e.r});
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0,
            $sformatf("%s_e%0d", tag, i + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    m_run    = 1'b0;
    m_cnt    = 5'd0;
    for (int i = 0; i < 32; i++) m_mem[i] = 32'hdead_beef;
    reset = 1'b1;
    regwr = 1'b0;
    rw    = '0;
    busw  = '0;
    ra    = '0;
    rb    = '0;

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, $sformatf("rst%0d", i));
    end
    sweep("sw1");
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 5'(i), 5'(31 - i),
            $sformatf("zero_r%0d", i));
    end

    drive(1'b0, 1'b1, 5'd8, 32'h800f_0000, 5'd0, 5'd0, "wr8");
    drive(1'b0, 1'b0, 5'd0, '0, 5'd8, 5'd9, "rd8");

    drive(1'b0, 1'b1, 5'd0, 32'hffff_ffff, 5'd0, 5'd0, "wr0");
    drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd8, "rd0");

    drive(1'b0, 1'b1, 5'd5, 32'h0002_c000, 5'd5, 5'd5, "byp_ab");
    drive(1'b0, 1'b1, 5'd6, 32'h0bad_f00d, 5'd5, 5'd6, "byp_b");
    drive(1'b0, 1'b1, 5'd31, 32'h7fff_ffff, 5'd31, 5'd6, "byp_a31");
    drive(1'b0, 1'b0, 5'd0, '0, 5'd31, 5'd5, "rd31");

    for (int i = 0; i < 9; i++) begin
      drive(1'b1 & (i < 1), 1'b0, 5'd0, '0, 5'd0, 5'd0,
            $sformatf("rst2_%0d", i));
    end
    drive(1'b1, 1'b0, 5'd0, '0, 5'd0, 5'd0, "mid_rst");
    drive(1'b0, 1'b1, 5'd7, 32'hcafe_babe, 5'd7, 5'd7, "early_wr");
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, '0, 5'd0, 5'd0, $sformatf("sw2_e%0d", i + 1));
    end
    drive(1'b0, 1'b0, 5'd0, '0, 5'd7, 5'd8, "rd7");

    drive(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0, "wr3");
    drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd3, "rd3");
    drive(1'b1, 1'b0, 5'd0, '0, 5'd3, 5'd3, "run_rst");
    sweep("sw3");
    drive(1'b0, 1'b0, 5'd0, '0, 5'd3, 5'd8, "rd3_clr");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
